// File: rtl/f_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : f_pc_sequencer
// Purpose  : Fetch-stage PC sequencer. Redirects on j/jal/jr, resolves
//            conditional branches in a one-cycle RESOLVE state and squashes
//            the wrong-path fetch via o_flush.
// Revision : 1.0  initial release
// ============================================================================
module f_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_dec_valid,
    input  logic [1:0]  i_jump,
    input  logic [2:0]  i_bop,
    input  logic        i_ifstall,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_index,
    input  logic [31:0] i_dec_pc4,
    output logic [31:0] o_pc,
    output logic        o_fetch_valid,
    output logic        o_flush,
    output logic        o_br_taken
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RESOLVE = 1'b1
    } state_t;

    localparam logic [1:0] c_JMP_BRANCH = 2'b00;
    localparam logic [1:0] c_JMP_J      = 2'b01;
    localparam logic [1:0] c_JMP_JR     = 2'b10;

    localparam logic [2:0] c_BOP_NONE = 3'b000;
    localparam logic [2:0] c_BOP_BEQ  = 3'b001;
    localparam logic [2:0] c_BOP_BNE  = 3'b010;
    localparam logic [2:0] c_BOP_BLEZ = 3'b011;
    localparam logic [2:0] c_BOP_BGTZ = 3'b100;
    localparam logic [2:0] c_BOP_BLTZ = 3'b101;
    localparam logic [2:0] c_BOP_BGEZ = 3'b110;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_fetch_valid;
    logic        w_fv_nxt;
    logic        w_latch;
    logic        w_flush;
    logic        w_br_taken;

    // Branch operands captured at decode so RESOLVE is independent of
    // whatever the decode stage presents in the following cycle.
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [15:0] r_imm;
    logic [31:0] r_pc4;
    logic [2:0]  r_bop;

    logic        w_dec_fire;
    logic        w_is_branch;
    logic        w_taken;
    logic [31:0] w_j_target;
    logic [31:0] w_br_target;

    assign w_dec_fire  = i_dec_valid & ~i_stall & (r_state == ST_RUN);
    assign w_is_branch = (i_jump == c_JMP_BRANCH) & i_ifstall & (i_bop != c_BOP_NONE);
    assign w_j_target  = {i_dec_pc4[31:28], i_index, 2'b00};
    assign w_br_target = r_pc4 + {{14{r_imm[15]}}, r_imm, 2'b00};

    always_comb begin
        w_taken = 1'b0;
        case (r_bop)
            c_BOP_BEQ:  w_taken = (r_rs == r_rt);
            c_BOP_BNE:  w_taken = (r_rs != r_rt);
            c_BOP_BLEZ: w_taken = ($signed(r_rs) <= 32'sd0);
            c_BOP_BGTZ: w_taken = ($signed(r_rs) >  32'sd0);
            c_BOP_BLTZ: w_taken = ($signed(r_rs) <  32'sd0);
            c_BOP_BGEZ: w_taken = ($signed(r_rs) >= 32'sd0);
            default:    w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fv_nxt    = r_fetch_valid;
        w_latch     = 1'b0;
        w_flush     = 1'b0;
        w_br_taken  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!i_stall) begin
                    w_fv_nxt = 1'b1;
                    if (w_dec_fire && (i_jump == c_JMP_J)) begin
                        w_pc_nxt = w_j_target;
                        w_flush  = 1'b1;
                    end else if (w_dec_fire && (i_jump == c_JMP_JR)) begin
                        w_pc_nxt = i_rs_val;
                        w_flush  = 1'b1;
                    end else if (w_dec_fire && w_is_branch) begin
                        // Hold PC and drop valid: the bubble covers resolution.
                        w_latch     = 1'b1;
                        w_flush     = 1'b1;
                        w_fv_nxt    = 1'b0;
                        w_state_nxt = ST_RESOLVE;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            ST_RESOLVE: begin
                if (!i_stall) begin
                    w_br_taken  = w_taken;
                    w_pc_nxt    = w_taken ? w_br_target : r_pc4;
                    w_fv_nxt    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= w_fv_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rs  <= 32'd0;
            r_rt  <= 32'd0;
            r_imm <= 16'd0;
            r_pc4 <= 32'd0;
            r_bop <= 3'd0;
        end else if (w_latch) begin
            r_rs  <= i_rs_val;
            r_rt  <= i_rt_val;
            r_imm <= i_imm;
            r_pc4 <= i_dec_pc4;
            r_bop <= i_bop;
        end
    end

    assign o_pc          = r_pc;
    assign o_fetch_valid = r_fetch_valid;
    assign o_flush       = w_flush;
    assign o_br_taken    = w_br_taken;

endmodule
`default_nettype wire

// File: tb/tb_f_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_pc_sequencer
// Purpose  : Directed self-checking bench for f_pc_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_f_pc_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_dec_valid = 1'b0;
    logic [1:0]  i_jump = 2'b00;
    logic [2:0]  i_bop = 3'b000;
    logic        i_ifstall = 1'b0;
    logic [31:0] i_rs_val = 32'd0;
    logic [31:0] i_rt_val = 32'd0;
    logic [15:0] i_imm = 16'd0;
    logic [25:0] i_index = 26'd0;
    logic [31:0] i_dec_pc4 = 32'd0;
    logic [31:0] o_pc;
    logic        o_fetch_valid;
    logic        o_flush;
    logic        o_br_taken;

    int checks = 0;
    int errors = 0;

    f_pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_stall      (i_stall),
        .i_dec_valid  (i_dec_valid),
        .i_jump       (i_jump),
        .i_bop        (i_bop),
        .i_ifstall    (i_ifstall),
        .i_rs_val     (i_rs_val),
        .i_rt_val     (i_rt_val),
        .i_imm        (i_imm),
        .i_index      (i_index),
        .i_dec_pc4    (i_dec_pc4),
        .o_pc         (o_pc),
        .o_fetch_valid(o_fetch_valid),
        .o_flush      (o_flush),
        .o_br_taken   (o_br_taken)
    );

    always #5 i_clk = ~i_clk;

    // Advance one edge; outputs and inputs then settle 1 time unit later.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_dec_valid = 1'b0;
        i_jump      = 2'b00;
        i_bop       = 3'b000;
        i_ifstall   = 1'b0;
        i_stall     = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", o_pc, 32'h0); end
        checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", o_fetch_valid); end
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", o_flush); end
        i_rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (o_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", k, o_pc, 32'(4 * k)); end
            checks++; if (o_fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv[%0d] got %b exp 1", k, o_fetch_valid); end
            checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL seq_flush[%0d] got %b exp 0", k, o_flush); end
        end
    endtask

    task automatic test_jump();
        i_dec_valid = 1'b1; i_jump = 2'b01; i_index = 26'h000_0040; i_dec_pc4 = 32'h1000_0008;
        #1;
        checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL j_flush got %b exp 1", o_flush); end
        step();
        checks++; if (o_pc !== 32'h1000_0100) begin errors++; $display("FAIL j_pc got %h exp %h", o_pc, 32'h1000_0100); end
        idle_inputs();
        #1;
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL j_flush_drop got %b exp 0", o_flush); end
        step();
        checks++; if (o_pc !== 32'h1000_0104) begin errors++; $display("FAIL j_seq_pc got %h exp %h", o_pc, 32'h1000_0104); end
    endtask

    task automatic test_branch_taken();
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b001; i_ifstall = 1'b1;
        i_rs_val = 32'd5; i_rt_val = 32'd5; i_imm = 16'hFFFE; i_dec_pc4 = 32'h0000_0020;
        #1;
        checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL beq_flush got %b exp 1", o_flush); end
        step();
        checks++; if (o_pc !== 32'h1000_0104) begin errors++; $display("FAIL beq_hold_pc got %h exp %h", o_pc, 32'h1000_0104); end
        checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL beq_bubble_fv got %b exp 0", o_fetch_valid); end
        // Decode inputs change during RESOLVE and must be ignored.
        i_rs_val = 32'd0; i_jump = 2'b01; i_index = 26'h3FF_FFFF;
        #1;
        checks++; if (o_br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", o_br_taken); end
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL beq_resolve_flush got %b exp 0", o_flush); end
        step();
        idle_inputs();
        checks++; if (o_pc !== 32'h0000_0018) begin errors++; $display("FAIL beq_target got %h exp %h", o_pc, 32'h0000_0018); end
        checks++; if (o_fetch_valid !== 1'b1) begin errors++; $display("FAIL beq_fv got %b exp 1", o_fetch_valid); end
        #1;
        checks++; if (o_br_taken !== 1'b0) begin errors++; $display("FAIL beq_taken_drop got %b exp 0", o_br_taken); end
    endtask

    task automatic test_branch_not_taken();
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b110; i_ifstall = 1'b1;
        i_rs_val = 32'h8000_0000; i_imm = 16'h0010; i_dec_pc4 = 32'h0000_0040;
        step();
        idle_inputs();
        #1;
        checks++; if (o_br_taken !== 1'b0) begin errors++; $display("FAIL bgez_taken got %b exp 0", o_br_taken); end
        step();
        checks++; if (o_pc !== 32'h0000_0040) begin errors++; $display("FAIL bgez_pc got %h exp %h", o_pc, 32'h0000_0040); end
    endtask

    task automatic test_bop_none();
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b000; i_ifstall = 1'b1;
        #1;
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL bopnone_flush got %b exp 0", o_flush); end
        step();
        idle_inputs();
        checks++; if (o_pc !== 32'h0000_0044) begin errors++; $display("FAIL bopnone_pc got %h exp %h", o_pc, 32'h0000_0044); end
        checks++; if (o_fetch_valid !== 1'b1) begin errors++; $display("FAIL bopnone_fv got %b exp 1", o_fetch_valid); end
    endtask

    task automatic test_jr_stall();
        i_dec_valid = 1'b1; i_jump = 2'b10; i_rs_val = 32'h0000_0200; i_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL jr_stall_flush[%0d] got %b exp 0", k, o_flush); end
            step();
            checks++; if (o_pc !== 32'h0000_0044) begin errors++; $display("FAIL jr_stall_pc[%0d] got %h exp %h", k, o_pc, 32'h0000_0044); end
        end
        i_stall = 1'b0;
        #1;
        checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL jr_flush got %b exp 1", o_flush); end
        step();
        idle_inputs();
        checks++; if (o_pc !== 32'h0000_0200) begin errors++; $display("FAIL jr_pc got %h exp %h", o_pc, 32'h0000_0200); end
    endtask

    task automatic test_resolve_stall();
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b010; i_ifstall = 1'b1;
        i_rs_val = 32'd1; i_rt_val = 32'd2; i_imm = 16'h0010; i_dec_pc4 = 32'h0000_0300;
        step();
        idle_inputs();
        i_stall = 1'b1;
        #1;
        checks++; if (o_br_taken !== 1'b0) begin errors++; $display("FAIL bne_stall_taken got %b exp 0", o_br_taken); end
        step();
        checks++; if (o_pc !== 32'h0000_0200) begin errors++; $display("FAIL bne_stall_pc got %h exp %h", o_pc, 32'h0000_0200); end
        checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL bne_stall_fv got %b exp 0", o_fetch_valid); end
        i_stall = 1'b0;
        #1;
        checks++; if (o_br_taken !== 1'b1) begin errors++; $display("FAIL bne_taken got %b exp 1", o_br_taken); end
        step();
        checks++; if (o_pc !== 32'h0000_0340) begin errors++; $display("FAIL bne_target got %h exp %h", o_pc, 32'h0000_0340); end
    endtask

    task automatic test_blez_bltz();
        // blez with rs=0 is taken; bltz with rs=0 is not.
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b011; i_ifstall = 1'b1;
        i_rs_val = 32'd0; i_imm = 16'h0001; i_dec_pc4 = 32'h0000_0500;
        step();
        idle_inputs();
        step();
        checks++; if (o_pc !== 32'h0000_0504) begin errors++; $display("FAIL blez_pc got %h exp %h", o_pc, 32'h0000_0504); end
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b101; i_ifstall = 1'b1;
        i_rs_val = 32'd0; i_imm = 16'h0001; i_dec_pc4 = 32'h0000_0600;
        step();
        idle_inputs();
        step();
        checks++; if (o_pc !== 32'h0000_0600) begin errors++; $display("FAIL bltz_pc got %h exp %h", o_pc, 32'h0000_0600); end
    endtask

    task automatic test_wrap();
        i_dec_valid = 1'b1; i_jump = 2'b10; i_rs_val = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        checks++; if (o_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp %h", o_pc, 32'hFFFF_FFFC); end
        step();
        checks++; if (o_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc got %h exp %h", o_pc, 32'h0); end
    endtask

    task automatic test_reset_in_resolve();
        i_dec_valid = 1'b1; i_jump = 2'b00; i_bop = 3'b001; i_ifstall = 1'b1;
        i_rs_val = 32'd7; i_rt_val = 32'd7; i_imm = 16'h0100; i_dec_pc4 = 32'h0000_0800;
        step();
        idle_inputs();
        i_rst = 1'b1;
        #1;
        checks++; if (o_pc !== 32'h0000_0000) begin errors++; $display("FAIL rst_resolve_pc got %h exp %h", o_pc, 32'h0); end
        checks++; if (o_br_taken !== 1'b0) begin errors++; $display("FAIL rst_resolve_taken got %b exp 0", o_br_taken); end
        checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_resolve_fv got %b exp 0", o_fetch_valid); end
        step();
        i_rst = 1'b0;
        step();
        checks++; if (o_pc !== 32'h0000_0004) begin errors++; $display("FAIL rst_resolve_after got %h exp %h", o_pc, 32'h4); end
        checks++; if (o_fetch_valid !== 1'b1) begin errors++; $display("FAIL rst_resolve_after_fv got %b exp 1", o_fetch_valid); end
    endtask

    initial begin
        step();
        step();
        test_reset();
        test_jump();
        test_branch_taken();
        test_branch_not_taken();
        test_bop_none();
        test_jr_stall();
        test_resolve_stall();
        test_blez_bltz();
        test_wrap();
        test_reset_in_resolve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
